issue_arbiter: RTL
==================

# issue_arbiter

Oldest-first issue select for one reservation station. The block consumes the per-entry `reqs` vector from the `wakeup` block and drives its `grant`/`grant_valid` inputs. It runs a valid/ready handshake toward the functional unit and broadcasts a delayed wakeup tag for dependent entries once an issued entry's result is due. Age order is tracked with an age matrix that is updated on every dispatch.

## Interface
- `RS_ENTRIES`, default `CORE_PKG::RS_ENTRIES` (8): number of RS entries.
- `ENTRY_W`, default `$clog2(RS_ENTRIES)`: entry index width.
- `FU_LATENCY`, default 1: cycles from issue fire to wakeup broadcast. Legal range is 1..8.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-low.
- `alloc_valid`  in  1: an entry is dispatched this cycle.
- `alloc_entry`  in  ENTRY_W: index of the dispatched entry.
- `reqs`  in  RS_ENTRIES: ready-to-issue entries, from `wakeup`.
- `flush`  in  1: squash all scheduler state.
- `fu_ready`  in  1: the FU accepts an issue this cycle.
- `grant`  out  RS_ENTRIES: one-hot selected entry; all zero when nothing is selected.
- `grant_valid`  out  1: `grant` is valid.
- `grant_entry`  out  ENTRY_W: encoded index of `grant`.
- `wakeup_valid`  out  1: result tag broadcast.
- `wakeup_entry`  out  ENTRY_W: entry whose result is now available.

## Operation
- **State**
  - Age matrix `older[i][j]`: 1 means entry i is older than entry j.
  - `issued` mask: one bit per entry.
  - Grant-lock register: a lock flag plus a locked index.
  - Wakeup shift pipe: `FU_LATENCY` stages of {valid, entry}.
- **Dispatch.** On `alloc_valid` with entry e:
  - clear row e and set column e (every other entry becomes older than e);
  - clear `issued[e]`.
- **Eligibility.** `elig = reqs & ~issued`.
- **Ordering.** Entry i beats entry j when `older[i][j] | (~older[j][i] & (i<j))`. This gives oldest-first order, with the lowest index winning when the matrix has no ordering for the pair.
- **Selection.** The winner is the eligible entry that beats every other eligible entry. Selection is combinational from the registered state and `reqs`.
- **Lock.** While the lock flag is set, `grant` is forced to the locked index regardless of `reqs` and age. The RS must hold `reqs` for the locked entry.
- **Grant valid.** `grant_valid = (lock | |elig) & ~flush`.
- **Fire.** `fire = grant_valid & fu_ready`.
  - On fire: set `issued[grant_entry]`, clear the lock, and push {1, `grant_entry`} into the wakeup pipe.
- **Stall.** When `grant_valid & ~fu_ready`: set the lock and capture the locked index.
- **Flush** (highest priority over every other event):
  - clear the lock, the `issued` mask, the age matrix, and all pipe stages;
  - `grant_valid` and `fire` are 0 in the flush cycle;
  - an `alloc` in the same cycle is dropped.
- **Same-cycle dispatch and request.** Alloc of e in the same cycle as `reqs[e]`: selection uses the pre-update matrix, and the matrix update lands at the edge.
- **Same-cycle dispatch and fire.** Alloc of e in the same cycle as a fire of e: the alloc wins, so `issued[e]` ends at 0.
- **Issue rate.** At most one fire per cycle.
- **Reset values.** All outputs are 0. Age matrix, `issued`, lock and pipe are all 0.

## Timing
- Grant latency is 0: `reqs` asserted in cycle N gives `grant` in cycle N.
- Fire in cycle N gives `wakeup_valid` in cycle N+`FU_LATENCY`, registered.
- A stalled grant is stable from the first stall cycle until the fire cycle inclusive.
- Back-to-back fires are allowed every cycle. The pipe accepts one entry per cycle and never backpressures.
- Reset asserted mid-stall or mid-pipe clears everything asynchronously. The first grant after reset release can appear in the first cycle of release.

## Configuration
- `ISSUE_ARB_PERF_CNT_EN`
  - **Defined:** adds outputs `perf_issue_cnt` (32-bit, increments on fire) and `perf_stall_cnt` (32-bit, increments on `grant_valid & ~fu_ready`). Both counters wrap at 2^32, reset to 0 and are not cleared by `flush`.
  - **Undefined:** both ports and both counters are absent. All other behaviour is identical.

## Structure
- `CORE_PKG` carries:
  - `RS_ENTRIES`;
  - the `rs_idx_t` typedef (`logic [ENTRY_W-1:0]`);
  - a `wakeup_tag_t` struct {valid, entry}, used for the pipe stages and for `wakeup_valid`/`wakeup_entry`.
- Sub-module `age_matrix_sel`: holds the matrix and performs the update and the combinational winner selection. Its ports are the alloc inputs, the flush input, the `elig` vector and the one-hot winner output.
- Lock, `issued` mask, wakeup pipe and perf counters live in the top level.

## Test plan
- **Oldest-first order.** Alloc entries 3, 1, 5 in that order; then `reqs`=8'b0010_1010 with `fu_ready`=1 → grants 3, 1, 5 in consecutive cycles.
- **Tie-break after reset.** Right after reset, `reqs`=8'b0000_0110 with no alloc → grant = entry 1.
- **Stall hold.** Grant entry 2 with `fu_ready`=0 for 3 cycles, while an older entry 0 requests from stall cycle 2 → `grant` stays on 2 for all stall cycles. Entry 2 fires when `fu_ready`=1, and entry 0 is granted the next cycle.
- **Wakeup latency.** `FU_LATENCY`=3, entry 4 fires at cycle 10 → `wakeup_valid`=1 with `wakeup_entry`=4 at cycle 13 only.
- **Issued mask.** Entry 6 fires while `reqs[6]` stays high → entry 6 is not granted again until it is re-allocated.
- **Flush.** Flush during a stall with 2 wakeups in flight → `grant_valid`=0 that cycle, no `wakeup_valid` follows, and the lock is clear. With the macro defined, `perf_stall_cnt` keeps its value.

Source files
------------

// File: rtl/issue_arbiter_pkg.sv
// Shared reservation-station types used by the issue arbiter and its age matrix.
package core_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int ENTRY_W    = $clog2(RS_ENTRIES);

    typedef logic [ENTRY_W-1:0] rs_idx_t;

    typedef struct packed {
        logic    valid;
        rs_idx_t entry;
    } wakeup_tag_t;

endpackage

// File: rtl/issue_arbiter_age_matrix_sel.sv
// Age matrix for one reservation station plus the combinational oldest-first winner pick.
module age_matrix_sel #(
    parameter int RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int ENTRY_W    = $clog2(RS_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [ENTRY_W-1:0]    alloc_entry,
    input  logic                  flush,
    input  logic [RS_ENTRIES-1:0] elig,
    output logic [RS_ENTRIES-1:0] winner
);
    import core_pkg::*;

    // older[i][j] set means entry i was dispatched before entry j
    logic [RS_ENTRIES-1:0] older [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] beats_all;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) older[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) older[i] <= '0;
        end else if (alloc_valid) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (ENTRY_W'(i) == alloc_entry) older[i] <= '0;
                else                            older[i][alloc_entry] <= 1'b1;
            end
        end
    end

    // Pairs the matrix never ordered fall back to lowest index.
    always_comb begin
        beats_all = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            beats_all[i] = elig[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && elig[j] && !(older[i][j] || (!older[j][i] && (i < j))))
                    beats_all[i] = 1'b0;
            end
        end
    end

    assign winner = beats_all;

endmodule

// File: rtl/issue_arbiter.sv
// Oldest-first issue select with grant lock, issued mask and delayed wakeup broadcast.
// Optional perf counters are built when ISSUE_ARB_PERF_CNT_EN is defined.
module issue_arbiter #(
    parameter int RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int ENTRY_W    = $clog2(RS_ENTRIES),
    parameter int FU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [ENTRY_W-1:0]    alloc_entry,
    input  logic [RS_ENTRIES-1:0] reqs,
    input  logic                  flush,
    input  logic                  fu_ready,
    output logic [RS_ENTRIES-1:0] grant,
    output logic                  grant_valid,
    output logic [ENTRY_W-1:0]    grant_entry,
    output logic                  wakeup_valid,
    output logic [ENTRY_W-1:0]    wakeup_entry
`ifdef ISSUE_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_issue_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);
    import core_pkg::*;

    logic [RS_ENTRIES-1:0] issued;
    logic [RS_ENTRIES-1:0] elig;
    logic [RS_ENTRIES-1:0] winner;
    logic [RS_ENTRIES-1:0] sel;
    logic [ENTRY_W-1:0]    sel_entry;
    logic                  lock;
    logic [ENTRY_W-1:0]    lock_idx;
    logic                  fire;
    logic                  stall;
    wakeup_tag_t           pipe [FU_LATENCY];

    assign elig = reqs & ~issued;

    age_matrix_sel #(
        .RS_ENTRIES (RS_ENTRIES),
        .ENTRY_W    (ENTRY_W)
    ) u_age_matrix_sel (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_entry (alloc_entry),
        .flush       (flush),
        .elig        (elig),
        .winner      (winner)
    );

    // A stalled grant stays pinned to the captured entry until it fires.
    assign sel = lock ? (RS_ENTRIES'(1) << lock_idx) : winner;

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (sel[i]) sel_entry = ENTRY_W'(i);
        end
    end

    assign grant_valid = (lock | (|elig)) & ~flush;
    assign grant       = grant_valid ? sel : '0;
    assign grant_entry = grant_valid ? sel_entry : '0;
    assign fire        = grant_valid & fu_ready;
    assign stall       = grant_valid & ~fu_ready;

    // Alloc is applied after fire so a re-dispatch in the fire cycle clears issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
            issued   <= '0;
        end else if (flush) begin
            lock   <= 1'b0;
            issued <= '0;
        end else begin
            if (fire) begin
                lock                <= 1'b0;
                issued[grant_entry] <= 1'b1;
            end else if (stall) begin
                lock     <= 1'b1;
                lock_idx <= grant_entry;
            end
            if (alloc_valid) issued[alloc_entry] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FU_LATENCY; k++) pipe[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < FU_LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[0].valid <= fire;
            pipe[0].entry <= fire ? rs_idx_t'(grant_entry) : '0;
            for (int k = 1; k < FU_LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign wakeup_valid = pipe[FU_LATENCY-1].valid;
    assign wakeup_entry = ENTRY_W'(pipe[FU_LATENCY-1].entry);

`ifdef ISSUE_ARB_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fire)  perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
